// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, 16x16 register file with write-through bypass,
// load-use hazard detection, jump resolution and the ID/EX pipeline register.
module decode_stage #(
    parameter int NREGS  = 16,
    parameter int DWIDTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [19:0]       if_instruction,
    input  logic [DWIDTH-1:0] if_pc,
    input  logic              wb_enable,
    input  logic [3:0]        wb_dest,
    input  logic [DWIDTH-1:0] wb_data,
    output logic              stall,
    output logic              jumpEnable,
    output logic [DWIDTH-1:0] jumpAddress,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [3:0]        ex_dest,
    output logic [DWIDTH-1:0] ex_srcA,
    output logic [DWIDTH-1:0] ex_srcB,
    output logic [DWIDTH-1:0] ex_imm,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic [DWIDTH-1:0] ex_pc
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_LD   = 4'd5,
        OP_ST   = 4'd6,
        OP_ADDI = 4'd7,
        OP_JMP  = 4'd8,
        OP_JR   = 4'd9
    } opcode_e;

    // IF/ID pipeline register
    logic              if_valid;
    logic [19:0]       if_ir;
    logic [DWIDTH-1:0] if_pc_q;

    logic [DWIDTH-1:0] regs [NREGS];

    logic [3:0] op, ra, rb, rc;
    logic [DWIDTH-1:0] val_ra, val_rb, val_rc;

    logic [3:0]        dec_op;
    logic [3:0]        dec_dest;
    logic [DWIDTH-1:0] dec_src_a, dec_src_b, dec_imm;
    logic              dec_rw, dec_mr, dec_mw;
    logic              use_ra, use_rb, use_rc;
    logic              is_jump;
    logic [DWIDTH-1:0] jump_target;
    logic              hazard;

    assign op = if_ir[19:16];
    assign ra = if_ir[15:12];
    assign rb = if_ir[11:8];
    assign rc = if_ir[7:4];

    // NOTE: the register array has a reset branch because the design requires
    // every architectural register to read 0 after reset, not just R0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_enable && wb_dest != 4'd0) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Write-through bypass: a writeback in flight this cycle is visible to decode now.
    assign val_ra = (ra == 4'd0) ? '0 :
                    (wb_enable && wb_dest == ra) ? wb_data : regs[ra];
    assign val_rb = (rb == 4'd0) ? '0 :
                    (wb_enable && wb_dest == rb) ? wb_data : regs[rb];
    assign val_rc = (rc == 4'd0) ? '0 :
                    (wb_enable && wb_dest == rc) ? wb_data : regs[rc];

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        dec_op      = op;
        dec_dest    = 4'd0;
        dec_src_a   = '0;
        dec_src_b   = '0;
        dec_imm     = '0;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        use_ra      = 1'b0;
        use_rb      = 1'b0;
        use_rc      = 1'b0;
        is_jump     = 1'b0;
        jump_target = '0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec_dest  = ra;
                dec_src_a = val_rb;
                dec_src_b = val_rc;
                dec_rw    = 1'b1;
                use_rb    = 1'b1;
                use_rc    = 1'b1;
            end
            OP_LD: begin
                dec_dest  = ra;
                dec_src_a = val_rb;
                dec_rw    = 1'b1;
                dec_mr    = 1'b1;
                use_rb    = 1'b1;
            end
            OP_ST: begin
                dec_src_a = val_rb;
                dec_src_b = val_ra;
                dec_mw    = 1'b1;
                use_rb    = 1'b1;
                use_ra    = 1'b1;
            end
            OP_ADDI: begin
                dec_dest  = ra;
                dec_src_a = val_ra;
                dec_imm   = {{(DWIDTH-12){if_ir[11]}}, if_ir[11:0]};
                dec_rw    = 1'b1;
                use_ra    = 1'b1;
            end
            OP_JMP: begin
                is_jump     = 1'b1;
                jump_target = DWIDTH'(if_ir[15:0]);
            end
            OP_JR: begin
                is_jump     = 1'b1;
                jump_target = val_ra;
                use_ra      = 1'b1;
            end
            default: dec_op = OP_NOP;
        endcase
    end

    assign hazard = ex_valid && ex_memRead && (ex_dest != 4'd0) &&
                    ((use_ra && ra == ex_dest) ||
                     (use_rb && rb == ex_dest) ||
                     (use_rc && rc == ex_dest));

    assign stall       = if_valid && hazard;
    assign jumpEnable  = if_valid && !stall && is_jump;
    assign jumpAddress = jumpEnable ? jump_target : '0;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_valid <= 1'b0;
            if_ir    <= '0;
            if_pc_q  <= '0;
        end else if (jumpEnable) begin
            if_valid <= 1'b0;
            if_ir    <= '0;
        end else if (!stall) begin
            if_valid <= 1'b1;
            if_ir    <= if_instruction;
            if_pc_q  <= if_pc;
        end
    end

    // A stall or an empty IF/ID slot becomes an all-zero bubble in ID/EX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_dest     <= '0;
            ex_srcA     <= '0;
            ex_srcB     <= '0;
            ex_imm      <= '0;
            ex_regWrite <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_pc       <= '0;
        end else if (stall || !if_valid) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_dest     <= '0;
            ex_srcA     <= '0;
            ex_srcB     <= '0;
            ex_imm      <= '0;
            ex_regWrite <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_pc       <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_opcode   <= dec_op;
            ex_dest     <= dec_dest;
            ex_srcA     <= dec_src_a;
            ex_srcB     <= dec_src_b;
            ex_imm      <= dec_imm;
            ex_regWrite <= dec_rw;
            ex_memRead  <= dec_mr;
            ex_memWrite <= dec_mw;
            ex_pc       <= if_pc_q;
        end
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Holds the IF/ID pipeline register and decodes the 20-bit instruction.
- Reads a 16x16 register file, detects load-use hazards and resolves jumps.
- Drives the ID/EX register and returns stall, jumpAddress and jumpEnable to fetch; fetch must hold its PC while stall=1.

Parameters:
- NREGS, 16, register file depth (index width 4 fixed).
- DWIDTH, 16, data/address width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- if_instruction  input  20  instruction word from fetch.
- if_pc  input  16  PC (Daddress) of if_instruction.
- wb_enable  input  1  register-file write enable from writeback.
- wb_dest  input  4  writeback register index.
- wb_data  input  16  writeback data.
- stall  output  1  combinational; fetch holds PC, IF/ID holds.
- jumpEnable  output  1  combinational; fetch loads jumpAddress at next edge.
- jumpAddress  output  16  combinational jump target.
- ex_valid  output  1  ID/EX holds a real instruction.
- ex_opcode  output  4  registered opcode.
- ex_dest  output  4  registered destination index.
- ex_srcA  output  16  registered operand A.
- ex_srcB  output  16  registered operand B.
- ex_imm  output  16  registered sign-extended immediate.
- ex_regWrite, ex_memRead, ex_memWrite  output  1 each  registered controls.
- ex_pc  output  16  registered PC of the instruction.

Behaviour:
- Format: op=[19:16], ra=[15:12], rb=[11:8], rc=[7:4], imm12=[11:0], imm16=[15:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: ra<-rb op rc; srcA=R[rb], srcB=R[rc].
  - 5 LD ra<-mem[R[rb]]: memRead.
  - 6 ST mem[R[rb]]<-R[ra]: memWrite, srcA=R[rb], srcB=R[ra], no regWrite.
  - 7 ADDI ra<-R[ra]+sext(imm12): imm=sext imm12.
  - 8 JMP: target imm16.
  - 9 JR: target R[ra].
  - 10-15: treated as NOP, all controls 0.
- Register file:
  - Written at posedge when wb_enable=1 and wb_dest!=0.
  - R0 always reads 0.
  - Reads are combinational with write-through bypass: a read matching an active wb_dest returns wb_data the same cycle.
- IF/ID register: if_valid, if_ir, if_pc_q. Priority per edge: reset > flush > stall > load.
  - Load: latch if_instruction/if_pc, if_valid=1.
  - Flush: if_valid=0, if_ir=0.
  - Stall: hold.
- Load-use hazard: hazard = ex_valid & ex_memRead & ex_dest!=0 & ex_dest equals a source actually read by the ID instruction.
  - Sources: rb and rc for ALU ops; rb for LD; rb and ra for ST; ra for ADDI and JR.
  - stall = if_valid & hazard.
  - While stalled, the ID/EX register loads a bubble: ex_valid=0 and all controls 0.
  - Stall lasts exactly 1 cycle.
- Jump: jumpEnable = if_valid & ~stall & (op==8 | op==9); jumpAddress = target (0 when jumpEnable=0).
  - At the same edge the ID/EX register takes the jump as a NOP-control entry (ex_valid=1, controls 0) and IF/ID is flushed. The one wrongly fetched instruction is discarded.
  - A JR stalled on a load-use hazard does not assert jumpEnable until the stall clears.
- ID/EX update: when not stalled, the decoded fields are latched and ex_valid=if_valid.
- Reset (reset=0, asynchronous):
  - All ex_* outputs 0; if_valid=0; all registers 0.
  - stall=0 and jumpEnable=0 while reset is asserted.
  - Mid-operation reset discards any in-flight stall or jump.
- Latency: 1 cycle from IF/ID capture to ex_* outputs; stall and jump are decided in the same cycle the instruction sits in IF/ID.
- Arithmetic: sign extension of imm12 copies bit 11 into [15:12]. No arithmetic is done in this stage.

Test Plan:
1. Write R1=0x0005 via wb; present ADD r3,r1,r2 (0x13120) at pc 0x0004 -> next cycle ex_opcode=1, ex_dest=3, ex_srcA=0x0005, ex_srcB=0x0000, ex_regWrite=1, ex_pc=0x0004.
2. LD r2,[r1] then ADD r3,r2,r1 back-to-back -> stall=1 for exactly one cycle, one bubble (ex_valid=0), then the ADD appears with ex_valid=1.
3. JMP 0x0F1F (0x80F1F) in IF/ID -> jumpEnable=1, jumpAddress=0x0F1F that cycle; the following instruction is flushed (never reaches ex_valid=1).
4. ADDI r4,imm12=0xFFE with R4=3 -> ex_imm=0xFFFE, ex_srcA=0x0003.
5. wb_enable=1, wb_dest=1, wb_data=0xABCD in the same cycle ADD reads r1 -> ex_srcA=0xABCD. Writeback to R0 -> reads remain 0.
6. Assert reset=0 during a stall cycle -> all ex_* = 0, stall=0 and jumpEnable=0 immediately. After release, the first instruction decodes normally.
